// File: rtl/aes256_cbc_pkcs7_pad_pkg.sv
// Shared sizes and helpers for the AES-256-CBC PKCS#7 pad stage.
// Byte counts are derived from the bit-length constants of the core.
package aes256_cbc_pkcs7_pad_pkg;

   localparam int AES256_KEY_LENGTH = 256;
   localparam int AES_BLOCK_SIZE    = 128;
   localparam int AES256_KEY_BYTES  = AES256_KEY_LENGTH / 8;
   localparam int AES_BLOCK_BYTES   = AES_BLOCK_SIZE / 8;

   localparam int KEY_BYTES   = AES256_KEY_BYTES;
   localparam int IV_BYTES    = AES_BLOCK_BYTES;
   localparam int BLOCK_BYTES = AES_BLOCK_BYTES;
   localparam int AXIS_WIDTH  = 8;

   localparam logic [5:0] HDR_LAST = 6'(KEY_BYTES + IV_BYTES - 1);

   function automatic logic [4:0] pad_len(input logic [3:0] blk);
      return 5'(BLOCK_BYTES) - {1'b0, blk};
   endfunction

endpackage

// File: rtl/axis_if.sv
// Byte-wide AXI-Stream bundle with master/slave views.
// tkeep is a single bit because only 8-bit data is supported.
interface axis_if;
   import aes256_cbc_pkcs7_pad_pkg::*;

   logic [AXIS_WIDTH-1:0] tdata;
   logic                  tkeep;
   logic                  tlast;
   logic                  tuser;
   logic                  tvalid;
   logic                  tready;

   modport master (
      output tdata, tkeep, tlast, tuser, tvalid,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tlast, tuser, tvalid,
      output tready
   );

endinterface

// File: rtl/aes_axis_out_reg.sv
// One-entry AXIS output register; accepts a load whenever ready_o is high.
// Contents hold stable while the downstream stalls.
module aes_axis_out_reg
   import aes256_cbc_pkcs7_pad_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [AXIS_WIDTH-1:0] data_i,
   input  logic                  last_i,
   input  logic                  user_i,
   output logic                  ready_o,
   axis_if.master                m_axis
);

   logic                  valid_q, valid_d;
   logic                  keep_q, keep_d;
   logic                  last_q, last_d;
   logic                  user_q, user_d;
   logic [AXIS_WIDTH-1:0] data_q, data_d;

   assign ready_o = !valid_q | m_axis.tready;

   always_comb begin
      valid_d = valid_q;
      keep_d  = keep_q;
      last_d  = last_q;
      user_d  = user_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         keep_d  = 1'b1;
         last_d  = last_i;
         user_d  = user_i;
         data_d  = data_i;
      end else if (m_axis.tready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         keep_q  <= 1'b0;
         last_q  <= 1'b0;
         user_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         user_q  <= user_d;
         data_q  <= data_d;
      end
   end

   assign m_axis.tvalid = valid_q;
   assign m_axis.tkeep  = keep_q;
   assign m_axis.tlast  = last_q;
   assign m_axis.tuser  = user_q;
   assign m_axis.tdata  = data_q;

endmodule

// File: rtl/aes256_cbc_pkcs7_pad.sv
// Key/IV/payload pre-processor: PKCS#7-pads encrypt frames to whole blocks,
// passes decrypt frames through and flags payloads that are not block multiples.
module aes256_cbc_pkcs7_pad
   import aes256_cbc_pkcs7_pad_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   axis_if.slave  s_axis,
   axis_if.master m_axis,
   output logic   length_err
);

   typedef enum logic [2:0] {
      ST_HEADER  = 3'b001,
      ST_PAYLOAD = 3'b010,
      ST_PAD     = 3'b100
   } state_e;

   state_e                st_q, st_d;
   logic [5:0]            hdr_q, hdr_d;
   logic [3:0]            blk_q, blk_d;
   logic [4:0]            pad_q, pad_d;
   logic                  mode_q, mode_d;
   logic                  err_q, err_d;

   logic                  out_ready;
   logic                  in_acc;
   logic                  load;
   logic                  ld_last;
   logic                  ld_user;
   logic [AXIS_WIDTH-1:0] ld_data;
   logic [4:0]            pad_val;
   logic [3:0]            blk_inc;
   logic                  unused_tkeep;

   assign unused_tkeep   = s_axis.tkeep;
   assign s_axis.tready  = (st_q != ST_PAD) & out_ready;
   assign in_acc         = s_axis.tvalid & s_axis.tready;
   assign pad_val        = pad_len(blk_q);
   assign blk_inc        = blk_q + 4'd1;
   assign length_err     = err_q;

   always_comb begin
      st_d    = st_q;
      hdr_d   = hdr_q;
      blk_d   = blk_q;
      pad_d   = pad_q;
      mode_d  = mode_q;
      err_d   = 1'b0;
      load    = 1'b0;
      ld_data = s_axis.tdata;
      ld_last = 1'b0;
      ld_user = mode_q;
      unique case (st_q)
         ST_HEADER: begin
            if (in_acc) begin
               load = 1'b1;
               if (hdr_q == 6'd0) begin
                  mode_d  = s_axis.tuser;
                  ld_user = s_axis.tuser;
               end
               if (hdr_q == HDR_LAST) begin
                  hdr_d = 6'd0;
                  blk_d = 4'd0;
                  pad_d = 5'd0;
                  if (!s_axis.tlast) begin
                     st_d = ST_PAYLOAD;
                  end else if (mode_q) begin
                     st_d = ST_PAD;
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  hdr_d = hdr_q + 6'd1;
                  err_d = s_axis.tlast;
               end
            end
         end
         ST_PAYLOAD: begin
            if (in_acc) begin
               load  = 1'b1;
               blk_d = blk_inc;
               if (s_axis.tlast) begin
                  if (mode_q) begin
                     st_d = ST_PAD;
                  end else begin
                     ld_last = 1'b1;
                     st_d    = ST_HEADER;
                     err_d   = (blk_inc != 4'd0);
                  end
               end
            end
         end
         ST_PAD: begin
            // one pad byte per cycle while the output register can take it
            if (out_ready) begin
               load    = 1'b1;
               ld_data = {3'b000, pad_val};
               if (pad_q + 5'd1 == pad_val) begin
                  ld_last = 1'b1;
                  st_d    = ST_HEADER;
                  pad_d   = 5'd0;
                  blk_d   = 4'd0;
               end else begin
                  pad_d = pad_q + 5'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= ST_HEADER;
         hdr_q  <= 6'd0;
         blk_q  <= 4'd0;
         pad_q  <= 5'd0;
         mode_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         hdr_q  <= hdr_d;
         blk_q  <= blk_d;
         pad_q  <= pad_d;
         mode_q <= mode_d;
         err_q  <= err_d;
      end
   end

   aes_axis_out_reg u_out (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .data_i  (ld_data),
      .last_i  (ld_last),
      .user_i  (ld_user),
      .ready_o (out_ready),
      .m_axis  (m_axis)
   );

endmodule

// File: doc/aes256_cbc_pkcs7_pad.md
# aes256_cbc_pkcs7_pad

Byte-stream pre-processor placed directly upstream of the iterative AES-256-CBC core. It accepts frames of key (32 B), IV (16 B) and an arbitrary-length payload. For encrypt frames it appends PKCS#7 padding so the core always receives whole 16-byte blocks, with tlast only on the final padded byte. Decrypt frames pass through unchanged, and their payload length is checked.

## Interface
- KEY_BYTES, 32, key bytes at start of frame (`AES256_KEY_LENGTH/8)
- IV_BYTES, 16, IV bytes following key (`AES_BLOCK_SIZE/8)
- BLOCK_BYTES, 16, cipher block size in bytes
- AXIS_WIDTH, 8, data width of both ports; only 8 is supported
- Clk  input  1  clock
- Rst  input  1  asynchronous, active-high reset
- S_axis  axis_if.slave  8-bit tdata, tkeep, tlast, tuser  input frames; tuser=1 encrypt, 0 decrypt
- M_axis  axis_if.master  8-bit tdata, tkeep, tlast, tuser  padded frames to the CBC core
- Length_err  output  1  one-cycle pulse on a malformed frame

## Operation
- Frame = KEY_BYTES + IV_BYTES header bytes, then N ≥ 0 payload bytes. Input tlast marks the last byte of the frame.
- Mode is captured from S_axis.tuser on header byte 0. The captured value drives M_axis.tuser on every output byte of the frame. Input tuser on later bytes is ignored.
- States:
  - ST_HEADER: forward bytes and count with hdr_cnt (0..47).
    - Output tlast is forced 0.
    - Input tlast on a header byte with hdr_cnt < 47: ignored and not forwarded; Length_err pulses; counting continues.
    - Byte 47 accepted without tlast -> ST_PAYLOAD.
    - Byte 47 accepted with tlast: encrypt -> ST_PAD with blk_cnt=0; decrypt -> Length_err pulse, -> ST_HEADER.
  - ST_PAYLOAD: forward bytes; blk_cnt = N mod 16 (4-bit, wraps 15->0).
    - Encrypt, last byte (tlast): forwarded with tlast=0 -> ST_PAD.
    - Decrypt, last byte: forwarded with tlast=1 -> ST_HEADER. Length_err pulses if blk_cnt after that byte ≠ 0.
  - ST_PAD: S_axis.tready=0. Emit pad_val = 16 − blk_cnt bytes, each of value pad_val; blk_cnt=0 gives a full block of 0x10. pad_cnt counts emitted bytes. tlast=1 on the last pad byte -> ST_HEADER.
- M_axis.tkeep = 1 on every byte. Input tkeep is ignored.
- Output length (encrypt) = 48 + 16·(floor(N/16)+1). Output length (decrypt) = 48 + N.

## Timing
- Output is a one-entry pipeline register: 1-cycle latency, 1 byte/cycle sustained.
- S_axis.tready = (state ≠ ST_PAD) & (!M_axis.tvalid | M_axis.tready).
- In ST_PAD, one pad byte is loaded per cycle whenever the register is empty or draining.
- Padding costs pad_val cycles, during which input is stalled.
- Next frame's header byte 0 is accepted in the cycle after the last pad byte is loaded.
- While M_axis.tvalid & !M_axis.tready: tdata, tlast and tuser hold stable. No drop, no duplication.
- Length_err is registered and asserts the cycle after the offending beat is accepted.
- Reset (async) values:
  - state=ST_HEADER; hdr_cnt, blk_cnt and pad_cnt = 0.
  - M_axis.tvalid=0, tdata=0, tkeep=0, tlast=0, tuser=0; Length_err=0.
- Reset mid-frame discards the partial frame; the CBC core is reset by the same Rst.

## Structure
- Add AES256_KEY_BYTES and AES_BLOCK_BYTES, derived from the existing bit-length macros, to aes_defines.svh.
- State enum is one-hot and local to the module.
- Sub-module aes_axis_out_reg: a one-entry AXIS pipeline register with load/ready handshake, reusable by the downstream unpad stage.

## Test plan
- Encrypt, N=5 payload bytes -> 64 output bytes: header and payload unchanged, then 11 × 0x0B. tlast only on byte 63; tuser=1 on all bytes.
- Encrypt, N=16 -> 80 bytes; bytes 64..79 = 0x10; tlast on byte 79.
- Encrypt, N=0 (tlast on IV byte 47) -> 64 bytes; bytes 48..63 = 0x10; Length_err stays 0.
- Decrypt, N=32 -> 80 bytes identical to input, tlast on byte 79, Length_err=0.
- Decrypt, N=20 -> 68 bytes forwarded, tlast on byte 67, Length_err pulses exactly one cycle.
- Random 50% M_axis.tready stalls across an encrypt N=33 frame:
  - Output stream matches the reference padded stream (15 × 0x0F).
  - Data stable during stalls.
  - Assert Rst during ST_PAD: outputs go to reset values immediately, and the following frame pads correctly.
